// File: rtl/ec_point_validator.sv
// Checks a 14-bit {y,x} point against y^2 + xy = x^3 + A*x^2 + B over GF(2^7) with one bit-serial multiplier.
// Optional saturating invalid-result counter on err_count is enabled by defining ECV_ERR_COUNT_EN.
module ec_point_validator #(
    parameter logic [6:0] A    = 7'h01,
    parameter logic [6:0] B    = 7'h01,
    parameter logic [6:0] POLY = 7'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] point,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        is_inf,
    output logic [13:0] point_q
`ifdef ECV_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_MUL  = 2'd1;
    localparam logic [1:0] STATE_CMP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  stepCnt_q, stepCnt_d;
    logic [2:0]  prodSel_q, prodSel_d;
    logic [6:0]  acc_q, acc_d;
    logic [6:0]  x2_q, x2_d;
    logic [6:0]  y2_q, y2_d;
    logic [6:0]  xy_q, xy_d;
    logic [6:0]  x3_q, x3_d;
    logic [6:0]  ax2_q, ax2_d;
    logic [13:0] pointReg_q, pointReg_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic        isInf_q, isInf_d;
`ifdef ECV_ERR_COUNT_EN
    logic [7:0]  errCount_q, errCount_d;
`endif

    logic [6:0]  xVal, yVal;
    logic [6:0]  opA, opB;
    logic [2:0]  bitIdx;
    logic        opBit;
    logic [6:0]  accShift;
    logic [6:0]  accNext;
    logic [6:0]  lhs, rhs;
    logic        ptZero;
    logic        resultValid;

    assign xVal = pointReg_q[6:0];
    assign yVal = pointReg_q[13:7];

    // Operand pair for each of the five products, in evaluation order.
    always_comb begin
        opA = 7'h00;
        opB = 7'h00;
        case (prodSel_q)
            3'd0: begin opA = xVal; opB = xVal; end
            3'd1: begin opA = yVal; opB = yVal; end
            3'd2: begin opA = xVal; opB = yVal; end
            3'd3: begin opA = x2_q; opB = xVal; end
            3'd4: begin opA = A;    opB = x2_q; end
            default: begin opA = 7'h00; opB = 7'h00; end
        endcase
    end

    // One MSB-first shift-and-add step: doubling reduces by POLY when bit 6 shifts out.
    assign bitIdx   = 3'd6 - stepCnt_q;
    assign opBit    = opB[bitIdx];
    assign accShift = {acc_q[5:0], 1'b0} ^ (acc_q[6] ? POLY : 7'h00);
    assign accNext  = accShift ^ (opBit ? opA : 7'h00);

    assign lhs         = y2_q ^ xy_q;
    assign rhs         = x3_q ^ ax2_q ^ B;
    assign ptZero      = (pointReg_q == 14'h0000);
    assign resultValid = (lhs == rhs) | ptZero;

    always_comb begin
        state_d    = state_q;
        stepCnt_d  = stepCnt_q;
        prodSel_d  = prodSel_q;
        acc_d      = acc_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        xy_d       = xy_q;
        x3_d       = x3_q;
        ax2_d      = ax2_q;
        pointReg_d = pointReg_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        isInf_d    = isInf_q;
`ifdef ECV_ERR_COUNT_EN
        errCount_d = errCount_q;
`endif
        case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    pointReg_d = point;
                    valid_d    = 1'b0;
                    isInf_d    = 1'b0;
                    stepCnt_d  = 3'd0;
                    prodSel_d  = 3'd0;
                    acc_d      = 7'h00;
                    state_d    = STATE_MUL;
                end
            end
            STATE_MUL: begin
                acc_d     = accNext;
                stepCnt_d = stepCnt_q + 3'd1;
                if (stepCnt_q == 3'd6) begin
                    stepCnt_d = 3'd0;
                    acc_d     = 7'h00;
                    prodSel_d = prodSel_q + 3'd1;
                    case (prodSel_q)
                        3'd0:    x2_d  = accNext;
                        3'd1:    y2_d  = accNext;
                        3'd2:    xy_d  = accNext;
                        3'd3:    x3_d  = accNext;
                        default: ax2_d = accNext;
                    endcase
                    if (prodSel_q == 3'd4) begin
                        state_d = STATE_CMP;
                    end
                end
            end
            STATE_CMP: begin
                valid_d = resultValid;
                isInf_d = ptZero;
                done_d  = 1'b1;
                state_d = STATE_IDLE;
`ifdef ECV_ERR_COUNT_EN
                if (!resultValid && (errCount_q != 8'hFF)) begin
                    errCount_d = errCount_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_IDLE;
            stepCnt_q  <= 3'd0;
            prodSel_q  <= 3'd0;
            acc_q      <= 7'h00;
            x2_q       <= 7'h00;
            y2_q       <= 7'h00;
            xy_q       <= 7'h00;
            x3_q       <= 7'h00;
            ax2_q      <= 7'h00;
            pointReg_q <= 14'h0000;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            isInf_q    <= 1'b0;
`ifdef ECV_ERR_COUNT_EN
            errCount_q <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            stepCnt_q  <= stepCnt_d;
            prodSel_q  <= prodSel_d;
            acc_q      <= acc_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            xy_q       <= xy_d;
            x3_q       <= x3_d;
            ax2_q      <= ax2_d;
            pointReg_q <= pointReg_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            isInf_q    <= isInf_d;
`ifdef ECV_ERR_COUNT_EN
            errCount_q <= errCount_d;
`endif
        end
    end

    assign busy    = (state_q != STATE_IDLE);
    assign done    = done_q;
    assign valid   = valid_q;
    assign is_inf  = isInf_q;
    assign point_q = pointReg_q;
`ifdef ECV_ERR_COUNT_EN
    assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_ec_point_validator.sv
// Scoreboard bench for ec_point_validator; expected results come from an independent LSB-first GF(2^7) model.
// err_count checks are compiled in only when ECV_ERR_COUNT_EN is defined.
module tb_ec_point_validator;

    localparam logic [6:0] CURVE_A = 7'h01;
    localparam logic [6:0] CURVE_B = 7'h01;
    localparam logic [6:0] FIELD_POLY = 7'h03;
    localparam int LATENCY = 36;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] point;
    logic        busy;
    logic        done;
    logic        valid;
    logic        is_inf;
    logic [13:0] point_q;
`ifdef ECV_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    typedef struct packed {
        logic [13:0] pt;
        logic        v;
        logic        inf;
    } exp_t;

    exp_t sbQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   errModel = 0;

    ec_point_validator #(.A(CURVE_A), .B(CURVE_B), .POLY(FIELD_POLY)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .point   (point),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .is_inf  (is_inf),
        .point_q (point_q)
`ifdef ECV_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] refMul(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] r;
        logic [6:0] aa;
        r  = 7'h00;
        aa = a;
        for (int i = 0; i < 7; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[5:0], 1'b0} ^ (aa[6] ? FIELD_POLY : 7'h00);
        end
        return r;
    endfunction

    function automatic logic refOnCurve(input logic [13:0] p);
        logic [6:0] x;
        logic [6:0] y;
        logic [6:0] x2;
        x  = p[6:0];
        y  = p[13:7];
        x2 = refMul(x, x);
        if (p == 14'h0000) return 1'b1;
        return (refMul(y, y) ^ refMul(x, y)) == (refMul(x2, x) ^ refMul(CURVE_A, x2) ^ CURVE_B);
    endfunction

    function automatic exp_t popExpected();
        exp_t e;
        e.pt  = 14'h0000;
        e.v   = 1'bx;
        e.inf = 1'bx;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (!e.v && errModel < 255) errModel++;
        end
        return e;
    endfunction

    // Drives start for one cycle from a negedge; returns at the negedge after the accepting edge.
    task automatic startOp(input logic [13:0] p, input bit expectAccept);
        exp_t e;
        if (expectAccept) begin
            e.pt  = p;
            e.v   = refOnCurve(p);
            e.inf = (p == 14'h0000);
            sbQ.push_back(e);
        end
        start = 1'b1;
        point = p;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        point = 14'($urandom);
    endtask

    task automatic waitDone(output int lat, output bit seen);
        lat  = 0;
        seen = (done === 1'b1);
        while (!seen && lat < LATENCY + 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = (done === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        point = 14'h0000;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, valid, is_inf, point_q} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b valid=%b is_inf=%b point_q=%h, expected all 0",
                     busy, done, valid, is_inf, point_q);
        end
`ifdef ECV_ERR_COUNT_EN
        vectors++;
        if (err_count !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_err_count: got %h, expected 00", err_count);
        end
`endif
        errModel = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_on_curve();
        int lat;
        bit seen;
        exp_t e;
        startOp(14'h0080, 1'b1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL t1_busy_running: got %b, expected 1", busy);
        end
        waitDone(lat, seen);
        e = popExpected();
        vectors++;
        if (!seen || lat != LATENCY) begin
            miscompares++;
            $display("[TB] FAIL t1_latency: got %0d edges (seen=%0b), expected %0d", lat, seen, LATENCY);
        end
        vectors++;
        if ({valid, is_inf, point_q} !== {e.v, e.inf, e.pt}) begin
            miscompares++;
            $display("[TB] FAIL t1_result: got v=%b inf=%b pq=%h, expected v=%b inf=%b pq=%h",
                     valid, is_inf, point_q, e.v, e.inf, e.pt);
        end
        vectors++;
        if (valid !== 1'b1 || is_inf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL t1_valid: got v=%b inf=%b, expected v=1 inf=0", valid, is_inf);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL t1_busy_at_done: got %b, expected 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL t1_done_pulse: got done=%b valid=%b, expected done=0 valid=1", done, valid);
        end
    endtask

    task automatic test_curve_points();
        logic [13:0] pts [3];
        logic        want [3];
        int lat;
        bit seen;
        exp_t e;
        pts[0] = 14'h2E02; want[0] = 1'b1;
        pts[1] = 14'h2F02; want[1] = 1'b1;
        pts[2] = 14'h2E03; want[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            startOp(pts[i], 1'b1);
            waitDone(lat, seen);
            e = popExpected();
            vectors++;
            if (!seen || lat != LATENCY) begin
                miscompares++;
                $display("[TB] FAIL t2_latency[%0d]: got %0d edges (seen=%0b), expected %0d", i, lat, seen, LATENCY);
            end
            vectors++;
            if ({valid, is_inf, point_q} !== {e.v, e.inf, e.pt} || valid !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL t2_result[%0d]: got v=%b inf=%b pq=%h, expected v=%b inf=%b pq=%h",
                         i, valid, is_inf, point_q, want[i], e.inf, e.pt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invalid();
        int lat;
        bit seen;
        exp_t e;
        startOp(14'h0001, 1'b1);
        waitDone(lat, seen);
        e = popExpected();
        vectors++;
        if (!seen || valid !== 1'b0 || is_inf !== 1'b0 || point_q !== 14'h0001 || e.v !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL t3_invalid: got seen=%0b v=%b inf=%b pq=%h, expected seen=1 v=0 inf=0 pq=0001",
                     seen, valid, is_inf, point_q);
        end
`ifdef ECV_ERR_COUNT_EN
        vectors++;
        if (err_count !== 8'(errModel)) begin
            miscompares++;
            $display("[TB] FAIL t3_err_count_step: got %h, expected %h", err_count, 8'(errModel));
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            startOp(14'h0001, 1'b1);
            waitDone(lat, seen);
            e = popExpected();
        end
        vectors++;
        if (err_count !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL t3_err_count_sat: got %h, expected FF", err_count);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_infinity();
        int lat;
        bit seen;
        exp_t e;
        startOp(14'h0000, 1'b1);
        waitDone(lat, seen);
        e = popExpected();
        vectors++;
        if (!seen || lat != LATENCY) begin
            miscompares++;
            $display("[TB] FAIL t4_latency: got %0d edges (seen=%0b), expected %0d", lat, seen, LATENCY);
        end
        vectors++;
        if ({valid, is_inf, point_q} !== {e.v, e.inf, e.pt} || valid !== 1'b1 || is_inf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL t4_result: got v=%b inf=%b pq=%h, expected v=1 inf=1 pq=0000",
                     valid, is_inf, point_q);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int lat;
        bit seen;
        bit extraDone;
        exp_t e;
        startOp(14'h0001, 1'b1);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1;
        point = 14'h0080;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitDone(lat, seen);
        e = popExpected();
        vectors++;
        if (!seen || lat + 10 != LATENCY) begin
            miscompares++;
            $display("[TB] FAIL t5_latency: got %0d edges (seen=%0b), expected %0d", lat + 10, seen, LATENCY);
        end
        vectors++;
        if ({valid, is_inf, point_q} !== {e.v, e.inf, e.pt} || point_q !== 14'h0001) begin
            miscompares++;
            $display("[TB] FAIL t5_result: got v=%b inf=%b pq=%h, expected v=0 inf=0 pq=0001",
                     valid, is_inf, point_q);
        end
        extraDone = 1'b0;
        for (int i = 0; i < LATENCY + 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extraDone = 1'b1;
        end
        vectors++;
        if (extraDone) begin
            miscompares++;
            $display("[TB] FAIL t5_single_done: got extra activity=1, expected 0");
        end
    endtask

    task automatic test_reset_abort();
        bit sawDone;
        startOp(14'h0001, 1'b0);
        repeat (19) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, valid, is_inf, point_q} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL t6_abort_outputs: got busy=%b done=%b valid=%b is_inf=%b point_q=%h, expected all 0",
                     busy, done, valid, is_inf, point_q);
        end
        errModel = 0;
        sawDone = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < LATENCY; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        vectors++;
        if (sawDone) begin
            miscompares++;
            $display("[TB] FAIL t6_no_done: got activity after abort=1, expected 0");
        end
`ifdef ECV_ERR_COUNT_EN
        vectors++;
        if (err_count !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL t6_err_count_clear: got %h, expected 00", err_count);
        end
`endif
        test_on_curve();
    endtask

    task automatic test_back_to_back();
        logic [13:0] pts [3];
        int lat;
        bit seen;
        exp_t e;
        pts[0] = 14'h2E02;
        pts[1] = 14'h0001;
        pts[2] = 14'h0080;
        startOp(pts[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitDone(lat, seen);
            e = popExpected();
            vectors++;
            if (!seen || lat != LATENCY) begin
                miscompares++;
                $display("[TB] FAIL b2b_latency[%0d]: got %0d edges (seen=%0b), expected %0d", i, lat, seen, LATENCY);
            end
            vectors++;
            if ({valid, is_inf, point_q} !== {e.v, e.inf, e.pt}) begin
                miscompares++;
                $display("[TB] FAIL b2b_result[%0d]: got v=%b inf=%b pq=%h, expected v=%b inf=%b pq=%h",
                         i, valid, is_inf, point_q, e.v, e.inf, e.pt);
            end
            if (i < 2) startOp(pts[i + 1], 1'b1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [13:0] p;
        logic [6:0]  x;
        int lat;
        bit seen;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            p = 14'($urandom);
            if (i % 2 == 0) begin
                x = 7'($urandom_range(1, 127));
                p = {7'h00, x};
                for (int y = 0; y < 128; y++) begin
                    if (refOnCurve({7'(y), x})) p = {7'(y), x};
                end
            end
            startOp(p, 1'b1);
            waitDone(lat, seen);
            e = popExpected();
            vectors++;
            if (!seen || lat != LATENCY || {valid, is_inf, point_q} !== {e.v, e.inf, e.pt}) begin
                miscompares++;
                $display("[TB] FAIL rand[%0d]: got lat=%0d v=%b inf=%b pq=%h, expected lat=%0d v=%b inf=%b pq=%h",
                         i, lat, valid, is_inf, point_q, LATENCY, e.v, e.inf, e.pt);
            end
            @(negedge clk);
        end
`ifdef ECV_ERR_COUNT_EN
        vectors++;
        if (err_count !== 8'(errModel)) begin
            miscompares++;
            $display("[TB] FAIL rand_err_count: got %h, expected %h", err_count, 8'(errModel));
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        point = 14'h0000;
        test_reset();
        test_on_curve();
        test_curve_points();
        test_invalid();
        test_infinity();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
